// File: rtl/cpu_pkg.sv
// cpu_pkg: FSM state encoding, mode/opcode constants and instruction field widths
// shared by the control unit and its ALU.
package cpu_pkg;
   typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
   localparam int MODE_W = 1;
   localparam int OPC_W = 3;
   localparam logic MODE_ALU = 1'b0;
   localparam logic MODE_XFER = 1'b1;
   localparam logic [OPC_W-1:0] OP_NOP = 3'd0;
   localparam logic [OPC_W-1:0] OP_ADD = 3'd1;
   localparam logic [OPC_W-1:0] OP_SUB = 3'd2;
   localparam logic [OPC_W-1:0] OP_INC = 3'd3;
   localparam logic [OPC_W-1:0] OP_DEC = 3'd4;
   localparam logic [OPC_W-1:0] OP_AND = 3'd5;
   localparam logic [OPC_W-1:0] OP_OR = 3'd6;
   localparam logic [OPC_W-1:0] OP_XOR = 3'd7;
   localparam logic [OPC_W-1:0] OP_MOV = 3'd0;
   localparam logic [OPC_W-1:0] OP_CLR = 3'd1;
   localparam logic [OPC_W-1:0] OP_SHL = 3'd2;
   localparam logic [OPC_W-1:0] OP_SHR = 3'd3;
   function automatic int instr_width(input int reg_aw);
      return MODE_W + OPC_W + 2 * reg_aw;
   endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; the top bit of ext carries the carry/borrow/shifted-out bit,
// or the incoming carry for operations that leave it unchanged.
module alu_core
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              mode,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              c_in,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);
   logic [DATA_W:0] ext;
   always_comb begin
      ext = {c_in, a};
      if (mode == MODE_ALU) begin
         case (opcode)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext = {1'b0, a} - {1'b0, b};
            OP_INC:  ext = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
            OP_DEC:  ext = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
            OP_AND:  ext = {c_in, a & b};
            OP_OR:   ext = {c_in, a | b};
            OP_XOR:  ext = {c_in, a ^ b};
            default: ext = {c_in, a};
         endcase
      end else begin
         case (opcode)
            OP_MOV:  ext = {c_in, b};
            OP_CLR:  ext = {c_in, {DATA_W{1'b0}}};
            OP_SHL:  ext = {a, 1'b0};
            OP_SHR:  ext = {a[0], 1'b0, a[DATA_W-1:1]};
            default: ext = {c_in, a};
         endcase
      end
      result = ext[DATA_W-1:0];
      carry = ext[DATA_W];
      zero = ~|ext[DATA_W-1:0];
   end
endmodule

// File: rtl/param_control_unit.sv
// param_control_unit: four-cycle fetch/decode/execute/writeback core with an NREG x DATA_W
// register file, combinational debug read port and zero/carry flags.
module param_control_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG = 4,
   localparam int REG_AW = $clog2(NREG),
   localparam int INSTR_W = instr_width(REG_AW)
) (
   input  logic               clock_pulse,
   input  logic               resetn,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [REG_AW-1:0]  dbg_sel,
   output logic [DATA_W-1:0]  dbg_data,
   output logic               flag_z,
   output logic               flag_c,
   output logic               retire,
   output logic               illegal
);
   state_t state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
   logic res_c_q, res_c_d, res_z_q, res_z_d;
   logic flag_z_q, flag_z_d, flag_c_q, flag_c_d;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic mode, bad_op, wr_en;
   logic [OPC_W-1:0] opcode;
   logic [REG_AW-1:0] reg_a, reg_b;
   logic [DATA_W-1:0] alu_res;
   logic alu_c, alu_z;

   assign mode = ir_q[INSTR_W-1];
   assign opcode = ir_q[INSTR_W-2 -: OPC_W];
   assign reg_a = ir_q[2*REG_AW-1 -: REG_AW];
   assign reg_b = ir_q[REG_AW-1:0];
   assign bad_op = mode == MODE_XFER && opcode[OPC_W-1];
   assign wr_en = !bad_op && !(mode == MODE_ALU && opcode == OP_NOP);

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .mode(mode),
      .opcode(opcode),
      .a(op_a_q),
      .b(op_b_q),
      .c_in(flag_c_q),
      .result(alu_res),
      .carry(alu_c),
      .zero(alu_z)
   );

   always_ff @(posedge clock_pulse) begin
      if (!resetn) state_q <= FETCH;
      else state_q <= state_d;
   end

   always_comb
      state_d = state_q == FETCH ? (instr_valid ? DECODE : FETCH)
              : state_q == DECODE ? EXECUTE
              : state_q == EXECUTE ? WRITEBACK : FETCH;

   always_comb begin
      instr_ready = state_q == FETCH;
      retire = state_q == WRITEBACK;
      illegal = state_q == WRITEBACK && bad_op;
      dbg_data = regs_q[dbg_sel];
      flag_z = flag_z_q;
      flag_c = flag_c_q;
   end

   // Operands are captured together in DECODE, so regA == regB sees the old value twice.
   always_comb begin
      ir_d = state_q == FETCH && instr_valid ? instr_in : ir_q;
      op_a_d = state_q == DECODE ? regs_q[reg_a] : op_a_q;
      op_b_d = state_q == DECODE ? regs_q[reg_b] : op_b_q;
      res_d = state_q == EXECUTE ? alu_res : res_q;
      res_c_d = state_q == EXECUTE ? alu_c : res_c_q;
      res_z_d = state_q == EXECUTE ? alu_z : res_z_q;
      flag_c_d = state_q == WRITEBACK && wr_en ? res_c_q : flag_c_q;
      flag_z_d = state_q == WRITEBACK && wr_en ? res_z_q : flag_z_q;
      regs_d = regs_q;
      if (state_q == WRITEBACK && wr_en) regs_d[reg_a] = res_q;
   end

   always_ff @(posedge clock_pulse) begin
      if (!resetn) begin
         ir_q <= '0;
         op_a_q <= '0;
         op_b_q <= '0;
         res_q <= '0;
         res_c_q <= 1'b0;
         res_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
         regs_q <= '{default: '0};
      end else begin
         ir_q <= ir_d;
         op_a_q <= op_a_d;
         op_b_q <= op_b_d;
         res_q <= res_d;
         res_c_q <= res_c_d;
         res_z_q <= res_z_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
         regs_q <= regs_d;
      end
   end
endmodule

// File: tb/tb_param_control_unit.sv
// tb_param_control_unit: directed table plus random instructions on a 32-bit/4-register core
// and an 8-bit/8-register core, checked against an arithmetic reference model.
module tb_param_control_unit;
   localparam int PERIOD = 40;

   typedef struct {
      bit mode;
      bit [2:0] op;
      int ra;
      int rb;
      logic [63:0] exp_ra;
      bit exp_z;
      bit exp_c;
      bit exp_ill;
   } vec_t;

   logic clk = 1'b0;
   logic rn0, rn1, v0, v1, rdy0, rdy1, z0, c0, z1, c1, ret0, ret1, ill0, ill1;
   logic [7:0] instr0;
   logic [9:0] instr1;
   logic [1:0] sel0;
   logic [2:0] sel1;
   logic [31:0] dbg0;
   logic [7:0] dbg1;

   logic [63:0] m_r [2][8];
   bit m_z [2];
   bit m_c [2];
   int n_vec, n_err;

   always #(PERIOD / 2) clk = ~clk;

   param_control_unit #(.DATA_W(32), .NREG(4)) d0 (
      .clock_pulse(clk), .resetn(rn0), .instr_in(instr0), .instr_valid(v0), .instr_ready(rdy0),
      .dbg_sel(sel0), .dbg_data(dbg0), .flag_z(z0), .flag_c(c0), .retire(ret0), .illegal(ill0)
   );

   param_control_unit #(.DATA_W(8), .NREG(8)) d1 (
      .clock_pulse(clk), .resetn(rn1), .instr_in(instr1), .instr_valid(v1), .instr_ready(rdy1),
      .dbg_sel(sel1), .dbg_data(dbg1), .flag_z(z1), .flag_c(c1), .retire(ret1), .illegal(ill1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(input int d); return d == 0 ? rdy0 : rdy1; endfunction
   function automatic logic ret(input int d); return d == 0 ? ret0 : ret1; endfunction
   function automatic logic ill(input int d); return d == 0 ? ill0 : ill1; endfunction
   function automatic logic fz(input int d); return d == 0 ? z0 : z1; endfunction
   function automatic logic fc(input int d); return d == 0 ? c0 : c1; endfunction
   function automatic int nreg(input int d); return d == 0 ? 4 : 8; endfunction

   function automatic logic [9:0] enc(input int d, input bit mode, input bit [2:0] op, input int ra, input int rb);
      logic [2:0] a = 3'(ra);
      logic [2:0] b = 3'(rb);
      return d == 0 ? {2'b00, mode, op, a[1:0], b[1:0]} : {mode, op, a, b};
   endfunction

   task automatic drive(input int d, input logic v, input logic [9:0] ins);
      if (d == 0) begin v0 = v; instr0 = ins[7:0]; end
      else begin v1 = v; instr1 = ins; end
   endtask

   task automatic rd(input int d, input int i, output logic [63:0] v);
      if (d == 0) sel0 = 2'(i);
      else sel1 = 3'(i);
      #1;
      v = d == 0 ? 64'(dbg0) : 64'(dbg1);
   endtask

   task automatic model_reset(input int d);
      for (int i = 0; i < 8; i++) m_r[d][i] = '0;
      m_z[d] = 0;
      m_c[d] = 0;
   endtask

   task automatic model(input int d, input bit mode, input bit [2:0] op, input int ra, input int rb, output bit illg);
      int w = d == 0 ? 32 : 8;
      logic [63:0] mask = (64'd1 << w) - 64'd1;
      logic [63:0] a = m_r[d][ra];
      logic [63:0] b = m_r[d][rb];
      logic [63:0] r = a;
      bit c = m_c[d];
      bit wr = 1;
      illg = mode && op >= 3'd4;
      if (illg || (!mode && op == 3'd0)) wr = 0;
      else if (!mode) begin
         case (op)
            3'd1: begin r = a + b; c = r[w]; end
            3'd2: begin r = a - b; c = a < b; end
            3'd3: begin r = a + 64'd1; c = r[w]; end
            3'd4: begin r = a - 64'd1; c = a == 0; end
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
         endcase
      end else begin
         case (op)
            3'd0: r = b;
            3'd1: r = 0;
            3'd2: begin c = a[w-1]; r = a << 1; end
            default: begin c = a[0]; r = a >> 1; end
         endcase
      end
      if (wr) begin
         r &= mask;
         m_r[d][ra] = r;
         m_c[d] = c;
         m_z[d] = r == 0;
      end
   endtask

   task automatic check_state(input int d);
      logic [63:0] v;
      for (int i = 0; i < nreg(d); i++) begin
         rd(d, i, v);
         chk($sformatf("dut%0d_reg%0d", d, i), v, m_r[d][i]);
      end
      chk("flag_z", fz(d), m_z[d]);
      chk("flag_c", fc(d), m_c[d]);
      chk("retire_idle", ret(d), 0);
      chk("illegal_idle", ill(d), 0);
      chk("ready_idle", rdy(d), 1);
   endtask

   // Starts and ends just after a rising edge with the core in FETCH.
   task automatic exec(input int d, input bit mode, input bit [2:0] op, input int ra, input int rb,
                       output bit ill_seen, output time t_ret);
      logic [63:0] v;
      bit ill_exp;
      int k;
      drive(d, 1, enc(d, mode, op, ra, rb));
      @(negedge clk);
      chk("ready_in_fetch", rdy(d), 1);
      @(posedge clk);
      #1;
      k = 0;
      do begin
         drive(d, 1'($urandom), 10'($urandom));
         @(negedge clk);
         k++;
      end while (!ret(d) && k < 8);
      chk("retire_latency", k, 3);
      ill_seen = ill(d);
      t_ret = $time;
      rd(d, ra, v);
      chk("dbg_before_wb", v, m_r[d][ra]);
      model(d, mode, op, ra, rb, ill_exp);
      chk("illegal_pulse", ill_seen, ill_exp);
      @(posedge clk);
      #1;
      drive(d, 0, 0);
      check_state(d);
   endtask

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [17];
      logic [63:0] v;
      bit ills, illm;
      time t, t_prev;
      int cnt;
      tbl = '{
         '{0, 3'd3, 0, 0, 64'd1, 0, 0, 0},
         '{0, 3'd3, 0, 0, 64'd2, 0, 0, 0},
         '{0, 3'd3, 1, 0, 64'd1, 0, 0, 0},
         '{0, 3'd3, 1, 0, 64'd2, 0, 0, 0},
         '{0, 3'd3, 1, 0, 64'd3, 0, 0, 0},
         '{0, 3'd3, 1, 0, 64'd4, 0, 0, 0},
         '{0, 3'd3, 1, 0, 64'd5, 0, 0, 0},
         '{1, 3'd0, 2, 1, 64'd5, 0, 0, 0},
         '{0, 3'd2, 1, 2, 64'd0, 1, 0, 0},
         '{0, 3'd4, 1, 0, 64'hFFFF_FFFF, 0, 1, 0},
         '{1, 3'd5, 0, 1, 64'd2, 0, 1, 1},
         '{0, 3'd1, 1, 1, 64'hFFFF_FFFE, 0, 1, 0},
         '{1, 3'd3, 1, 0, 64'h7FFF_FFFF, 0, 0, 0},
         '{1, 3'd2, 0, 0, 64'd4, 0, 0, 0},
         '{0, 3'd0, 0, 0, 64'd4, 0, 0, 0},
         '{1, 3'd1, 0, 0, 64'd0, 1, 0, 0},
         '{0, 3'd7, 3, 1, 64'h7FFF_FFFF, 0, 0, 0}
      };
      n_vec = 0;
      n_err = 0;
      t_prev = 0;
      rn0 = 0; rn1 = 0;
      drive(0, 0, 0);
      drive(1, 0, 0);
      sel0 = 0; sel1 = 0;
      model_reset(0);
      model_reset(1);
      repeat (2) @(posedge clk);
      #1;
      rn0 = 1; rn1 = 1;
      check_state(0);
      check_state(1);

      foreach (tbl[i]) begin
         exec(0, tbl[i].mode, tbl[i].op, tbl[i].ra, tbl[i].rb, ills, t);
         rd(0, tbl[i].ra, v);
         chk($sformatf("tbl%0d_ra", i), v, tbl[i].exp_ra);
         chk($sformatf("tbl%0d_z", i), z0, tbl[i].exp_z);
         chk($sformatf("tbl%0d_c", i), c0, tbl[i].exp_c);
         chk($sformatf("tbl%0d_ill", i), ills, tbl[i].exp_ill);
         if (i == 1) chk("retire_spacing", 64'(t - t_prev), 64'(4 * PERIOD));
         t_prev = t;
      end

      drive(0, 1, enc(0, 0, 3'd3, 2, 0));
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (ret0) cnt++;
      end
      @(posedge clk);
      #1;
      drive(0, 0, 0);
      repeat (4) model(0, 0, 3'd3, 2, 0, illm);
      chk("held_valid_retires", cnt, 4);
      chk("held_valid_r2", m_r[0][2], 64'd9);
      check_state(0);

      for (int i = 0; i < 40; i++)
         exec(0, 1'($urandom), 3'($urandom), int'($urandom_range(3)), int'($urandom_range(3)), ills, t);

      drive(0, 1, enc(0, 0, 3'd1, 1, 2));
      @(posedge clk);
      #1;
      drive(0, 0, 0);
      @(posedge clk);
      #1;
      rn0 = 0;
      @(posedge clk);
      #1;
      rn0 = 1;
      model_reset(0);
      check_state(0);
      @(posedge clk);
      #1;
      check_state(0);

      exec(1, 0, 3'd4, 0, 0, ills, t);
      rd(1, 0, v);
      chk("w8_dec_r0", v, 64'hFF);
      chk("w8_dec_c", c1, 1);
      exec(1, 0, 3'd3, 1, 0, ills, t);
      exec(1, 0, 3'd1, 0, 1, ills, t);
      rd(1, 0, v);
      chk("w8_add_r0", v, 64'h00);
      chk("w8_add_z", z1, 1);
      chk("w8_add_c", c1, 1);
      exec(1, 1, 3'd0, 7, 1, ills, t);
      rd(1, 7, v);
      chk("w8_mov_r7", v, 64'h01);
      for (int i = 0; i < 30; i++)
         exec(1, 1'($urandom), 3'($urandom), int'($urandom_range(7)), int'($urandom_range(7)), ills, t);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/param_control_unit.md
PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and datapath width in bits (>=4).
REQ-002 SHALL have parameter NREG, default 4, register-file depth (power of two, >=2); REG_AW = clog2(NREG).
REQ-003 SHALL have derived parameter INSTR_W = 4 + 2*REG_AW; layout is mode[MSB], opcode[3 bits], regA[REG_AW], regB[REG_AW, LSBs].
REQ-004 SHALL have port clock_pulse  input  1  sole clock, rising-edge active.
REQ-005 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port instr_in  input  INSTR_W  machine-code instruction.
REQ-007 SHALL have port instr_valid  input  1  instr_in holds a valid instruction.
REQ-008 SHALL have port instr_ready  output  1  core will accept an instruction this cycle.
REQ-009 SHALL have port dbg_sel  input  REG_AW  register index for debug read.
REQ-010 SHALL have port dbg_data  output  DATA_W  combinational contents of register dbg_sel.
REQ-011 SHALL have ports flag_z, flag_c  output  1 each  zero and carry/borrow flags.
REQ-012 SHALL have ports retire, illegal  output  1 each  one-cycle pulses on instruction completion and on illegal opcode.

Function
REQ-013 SHALL implement FSM states FETCH, DECODE, EXECUTE, WRITEBACK; FETCH->DECODE only on instr_valid & instr_ready; DECODE->EXECUTE->WRITEBACK->FETCH unconditionally.
REQ-014 SHALL drive instr_ready = 1 exactly when in FETCH; instr_in is latched into IR on the accepting edge; instr_valid is ignored in every other state.
REQ-015 SHALL, in DECODE, register operand A = R[regA] and operand B = R[regB].
REQ-016 SHALL, in EXECUTE, register the ALU result and next flag values.
REQ-017 SHALL, in WRITEBACK, write the result to R[regA], update flags, and assert retire for that cycle; the next accept is possible on the following cycle (4 cycles per instruction minimum).
REQ-018 SHALL decode mode 0 opcodes as: 000 NOP, 001 ADD A+B, 010 SUB A-B, 011 INC A+1, 100 DEC A-1, 101 AND, 110 OR, 111 XOR.
REQ-019 SHALL decode mode 1 opcodes as: 000 MOV A<=B, 001 CLR A<=0, 010 SHL A<<1, 011 SHR A>>1 (logical); 100-111 are illegal.
REQ-020 SHALL wrap all arithmetic modulo 2^DATA_W; flag_c = carry-out for ADD/INC, borrow (A<B, or A==0 for DEC) for SUB/DEC, shifted-out bit for SHL/SHR, unchanged otherwise.
REQ-021 SHALL set flag_z = (result == 0) for every legal non-NOP instruction; NOP writes nothing and leaves flags unchanged but still retires.
REQ-022 SHALL, for an illegal instruction, suppress register write and flag update, pulse illegal and retire together in WRITEBACK.
REQ-023 SHALL, when regA == regB, use the pre-instruction value for both operands (e.g. ADD R1,R1 doubles R1).
REQ-024 SHALL make dbg_data reflect the register file value before a WRITEBACK edge and the new value after it.

Reset
REQ-025 SHALL, on a clock_pulse edge with resetn = 0, enter FETCH, clear all registers, IR, operand/result registers and flags to 0, and deassert retire and illegal.
REQ-026 SHALL abort any in-flight instruction on reset without writing back; instr_ready is 1 in the first cycle after resetn returns high.

Structure
REQ-027 SHALL place FSM state encoding, mode/opcode constants and the instruction field-extraction widths in shared package cpu_pkg.
REQ-028 SHALL implement the combinational ALU (result, carry, zero) as sub-module alu_core parametrised by DATA_W; the register file stays inside param_control_unit.

Verification
REQ-029 SHALL cover: reset, then INC R0 twice, with DATA_W=32 -> R0=2, retire pulses 4 cycles apart, flag_z=0.
REQ-030 SHALL cover: R1=5, R2=5, SUB R1,R2 -> R1=0, flag_z=1, flag_c=0; then DEC R1 -> R1=0xFFFFFFFF, flag_c=1.
REQ-031 SHALL cover: DATA_W=8, R0=0xFF, ADD R0 with R1=0x01 -> R0=0x00, flag_z=1, flag_c=1.
REQ-032 SHALL cover: mode 1 opcode 101 -> illegal and retire pulse together, all registers and flags unchanged.
REQ-033 SHALL cover: instr_valid held high continuously -> exactly one instruction accepted per 4 cycles; toggling instr_valid in DECODE/EXECUTE has no effect.
REQ-034 SHALL cover: resetn low during EXECUTE of ADD -> no writeback, all registers 0, instr_ready=1 the cycle after release; plus NREG=8 run writing R7 via MOV, read back on dbg_sel=7.
